mix_columns_seq: RTL and testbench
==================================

MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 The block SHALL have one parameter: COLS_PER_CYCLE, default 1, giving the number of 32-bit columns transformed per clock. The only legal values SHALL be 1, 2 and 4; any other value SHALL cause an elaboration error.
REQ-002 clk  input  1  Single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  Asynchronous, active-high reset.
REQ-004 in_valid  input  1  Input block present.
REQ-005 in_ready  output  1  Block can accept input.
REQ-006 in_state  input  128  AES state; column c SHALL occupy [127-32c -: 32]; row 0 byte SHALL be the top byte of each column.
REQ-007 in_inv  input  1  Selects the transform: 0 = MixColumns, 1 = InvMixColumns.
REQ-008 out_valid  output  1  Result available.
REQ-009 out_ready  input  1  Consumer accepts the result.
REQ-010 out_state  output  128  Transformed state, using the same byte layout as in_state.
REQ-011 busy  output  1  High in any state other than IDLE.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE. An accept occurs on an edge where in_valid=1 and in_ready=1.
REQ-014 On accept, the block SHALL latch in_state and in_inv (and in_bypass, when present), clear the column counter to 0, and enter RUN.
REQ-015 On each RUN edge, the block SHALL transform columns col_idx .. col_idx+COLS_PER_CYCLE-1 from the latched state into the result register, then advance col_idx by COLS_PER_CYCLE.
REQ-016 Column order SHALL be column 0 first. The counter SHALL wrap to 0.
REQ-017 After N = 4/COLS_PER_CYCLE RUN edges, the FSM SHALL enter DONE and assert out_valid. The latency from the accept edge to out_valid high SHALL be exactly N cycles.
REQ-018 In DONE, out_valid and out_state SHALL be held stable until an edge where out_ready=1; on that edge the FSM SHALL return to IDLE and drop out_valid.
REQ-019 out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
REQ-020 Input changes after accept SHALL NOT affect the result in progress.
REQ-021 out_state SHALL retain the last result after the handshake until the next accept overwrites it column by column.
REQ-022 Forward mode SHALL apply matrix rows [02 03 01 01], [01 02 03 01], [01 01 02 03], [03 01 01 02] over GF(2^8) with polynomial 0x11B.
REQ-023 Inverse mode SHALL apply rows [0E 0B 0D 09], [09 0E 0B 0D], [0D 09 0E 0B], [0B 0D 09 0E].
REQ-024 All multiplies SHALL be built from chained xtime operations: xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0x00), truncated to 8 bits.
REQ-025 Forward followed by inverse on any state SHALL return the original state.

Reset
REQ-026 While rst=1, independent of clk: FSM = IDLE, col_idx = 0, in_ready = 1, out_valid = 0, busy = 0, out_state = 0, and all latched state = 0.
REQ-027 Reset asserted during RUN or DONE SHALL abort the block in progress; no partial result SHALL be presented after reset.
REQ-028 After rst deasserts, the first accept is permitted on the first clk edge.

Configuration
REQ-029 Macro MIXCOL_BYPASS_EN: when defined, the block SHALL add port in_bypass (input, 1 bit), latched at accept. A latched 1 SHALL make the result equal the latched in_state, covering the AES final round with no MixColumns. Timing and handshake SHALL be identical to a normal block.
REQ-030 When MIXCOL_BYPASS_EN is undefined, in_bypass SHALL be absent and every accepted block SHALL be transformed.

Verification
REQ-031 COLS_PER_CYCLE=1, forward, column 0 = db135345, other columns 01010101 -> out_valid 4 cycles after accept; out_state = 8e4da1bc_01010101_01010101_01010101.
REQ-032 COLS_PER_CYCLE=4, inverse, state 8e4da1bc_9fdc589d_01010101_d5d5d7d6 -> out_valid 1 cycle after accept; out_state = db135345_f20a225c_01010101_d4d4d4d5.
REQ-033 COLS_PER_CYCLE=2, forward, state c6c6c6c6_2d26314c_f20a225c_d4d4d4d5 -> out_state = c6c6c6c6_4d7ebdf8_9fdc589d_d5d5d7d6 after 2 cycles; then hold out_ready=0 for 5 cycles -> out_valid and out_state stable and in_ready=0 throughout.
REQ-034 rst pulsed during the 2nd RUN cycle (COLS_PER_CYCLE=1) -> out_valid=0, out_state=0, in_ready=1 immediately; a following block completes normally in 4 cycles.
REQ-035 Back-to-back blocks with out_ready tied to 1 -> accepts spaced N+2 cycles apart; each result matches a software model; in_valid held high while busy never causes a second latch.
REQ-036 MIXCOL_BYPASS_EN defined, in_bypass=1, state d4d4d4d5_... -> out_state equals the input state, with latency N.

Source files
------------

// File: rtl/mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module   : mix_columns_seq
// Brief    : Sequential AES MixColumns / InvMixColumns over a 128-bit state,
//            COLS_PER_CYCLE columns per clock. Optional macro MIXCOL_BYPASS_EN
//            adds in_bypass (result = latched state, for the AES final round).
// Revision : 1.0 - initial release
// ============================================================================
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
`ifdef MIXCOL_BYPASS_EN
    input  logic         in_bypass,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
            $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // The step wraps naturally in 2 bits, so COLS_PER_CYCLE=4 steps by 0.
    localparam logic [1:0] c_step = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] c_last = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_col_idx;
    logic        r_inv;
    logic [31:0] r_src [4];
    logic [31:0] r_res [4];
    logic [32*COLS_PER_CYCLE-1:0] w_lanes;
    logic [2*COLS_PER_CYCLE-1:0]  w_sels;
`ifdef MIXCOL_BYPASS_EN
    logic        r_bypass;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant as an XOR of the x1/x2/x4/x8 xtime chain.
    function automatic logic [7:0] gmul4(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return ({8{k[0]}} & b) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] col, input logic inv);
        logic [7:0]  a [4];
        logic [3:0]  k [4];
        logic [31:0] res;
        for (int r = 0; r < 4; r++) a[r] = col[31-8*r -: 8];
        if (inv) begin
            k[0] = 4'he; k[1] = 4'hb; k[2] = 4'hd; k[3] = 4'h9;
        end else begin
            k[0] = 4'h2; k[1] = 4'h3; k[2] = 4'h1; k[3] = 4'h1;
        end
        res = '0;
        // Each matrix row is the first row rotated right by the row index.
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++)
                res[31-8*r -: 8] = res[31-8*r -: 8] ^ gmul4(a[j], k[2'(j - r)]);
        return res;
    endfunction

    always_comb begin
        w_lanes = '0;
        w_sels  = '0;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            w_sels[2*j +: 2] = r_col_idx + 2'(j);
`ifdef MIXCOL_BYPASS_EN
            w_lanes[32*j +: 32] = r_bypass ? r_src[w_sels[2*j +: 2]]
                                           : mixcol(r_src[w_sels[2*j +: 2]], r_inv);
`else
            w_lanes[32*j +: 32] = mixcol(r_src[w_sels[2*j +: 2]], r_inv);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_RUN;
            S_RUN:   if (r_col_idx == c_last) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_idx <= '0;
            r_inv     <= 1'b0;
`ifdef MIXCOL_BYPASS_EN
            r_bypass  <= 1'b0;
`endif
            for (int c = 0; c < 4; c++) begin
                r_src[c] <= '0;
                r_res[c] <= '0;
            end
        end else if (r_state == S_IDLE && in_valid) begin
            r_col_idx <= '0;
            r_inv     <= in_inv;
`ifdef MIXCOL_BYPASS_EN
            r_bypass  <= in_bypass;
`endif
            for (int c = 0; c < 4; c++) r_src[c] <= in_state[127-32*c -: 32];
        end else if (r_state == S_RUN) begin
            for (int j = 0; j < COLS_PER_CYCLE; j++)
                r_res[w_sels[2*j +: 2]] <= w_lanes[32*j +: 32];
            r_col_idx <= r_col_idx + c_step;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_state = {r_res[0], r_res[1], r_res[2], r_res[3]};

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mix_columns_seq
// Brief    : Self-checking bench for mix_columns_seq at COLS_PER_CYCLE 1, 2, 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mix_columns_seq;

    localparam int c_cpc [3] = '{1, 2, 4};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   in_valid  = '0;
    logic [2:0]   in_ready;
    logic [2:0]   in_inv    = '0;
    logic [2:0]   in_bypass = '0;
    logic [2:0]   out_valid;
    logic [2:0]   out_ready = '0;
    logic [2:0]   busy;
    logic [127:0] in_state  [3];
    logic [127:0] out_state [3];

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] sb_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_seq #(.COLS_PER_CYCLE(c_cpc[g])) dut (
`ifdef MIXCOL_BYPASS_EN
            .in_bypass (in_bypass[g]),
`endif
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .in_inv    (in_inv[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );
    end

    function automatic int n_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 2 : 1;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    logic [7:0] mfwd [16];
    logic [7:0] minv [16];

    function automatic logic [127:0] model(input logic [127:0] st, input logic inv);
        logic [127:0] res;
        logic [7:0]   a [4];
        logic [7:0]   acc, coef;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = st[127-32*c-8*r -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) begin
                    coef = inv ? minv[4*r+j] : mfwd[4*r+j];
                    acc  = acc ^ gmul(a[j], coef);
                end
                res[127-32*c-8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One full block: accept, disturb inputs, measure latency, optional hold, handshake.
    task automatic run_block(input int k, input logic [127:0] st, input logic inv,
                             input logic byp, input logic [127:0] exp, input int hold);
        int cyc;
        logic [127:0] e;
        chk("in_ready_idle", 128'(in_ready[k]), 128'd1);
        in_state[k] = st; in_inv[k] = inv; in_bypass[k] = byp; in_valid[k] = 1'b1;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        in_valid[k] = 1'b0; in_state[k] = ~st; in_inv[k] = ~inv; in_bypass[k] = ~byp;
        chk("busy_after_accept", {126'd0, in_ready[k], busy[k]}, 128'b01);
        cyc = 0;
        while (!out_valid[k] && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", 128'(cyc), 128'(n_of(k)));
        e = sb_q.pop_front();
        chk("result", out_state[k], e);
        for (int i = 0; i < hold; i++) begin
            in_valid[k] = 1'b1;
            @(posedge clk); #1;
            chk("hold_valid_ready", {126'd0, out_valid[k], in_ready[k]}, 128'b10);
            chk("hold_state", out_state[k], e);
        end
        in_valid[k] = 1'b0;
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        chk("release_valid_ready", {126'd0, out_valid[k], in_ready[k]}, 128'b01);
        chk("retained_state", out_state[k], e);
    endtask

    task automatic b2b(input int k);
        int cyc, nacc, npop;
        int acc_at [4];
        logic [127:0] blk [4];
        logic [127:0] e;
        for (int i = 0; i < 4; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
        out_ready[k] = 1'b1;
        nacc = 0; npop = 0; cyc = 0;
        while ((nacc < 4 || npop < 4) && cyc < 80) begin
            if (out_valid[k]) begin
                if (sb_q.size() == 0) chk("b2b_extra_result", 128'd1, 128'd0);
                else begin
                    e = sb_q.pop_front();
                    chk("b2b_result", out_state[k], e);
                    npop++;
                end
            end
            if (nacc == 4 && !in_ready[k]) in_valid[k] = 1'b0;
            if (in_ready[k] && nacc < 4) begin
                in_state[k] = blk[nacc];
                in_inv[k]   = nacc[0];
                in_valid[k] = 1'b1;
                sb_q.push_back(model(blk[nacc], nacc[0]));
                acc_at[nacc] = cyc;
                nacc++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("b2b_count", 128'(npop), 128'd4);
        for (int i = 1; i < 4; i++)
            chk("b2b_spacing", 128'(acc_at[i] - acc_at[i-1]), 128'(n_of(k) + 2));
        in_valid[k] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("b2b_no_extra", 128'(out_valid[k]), 128'd0);
        end
        out_ready[k] = 1'b0;
    endtask

    typedef struct {
        int           k;
        logic         inv;
        logic [127:0] st;
        logic [127:0] exp;
        int           hold;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] st, fw;
        mfwd = '{8'h02, 8'h03, 8'h01, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01,
                 8'h01, 8'h01, 8'h02, 8'h03, 8'h03, 8'h01, 8'h01, 8'h02};
        minv = '{8'h0e, 8'h0b, 8'h0d, 8'h09, 8'h09, 8'h0e, 8'h0b, 8'h0d,
                 8'h0d, 8'h09, 8'h0e, 8'h0b, 8'h0b, 8'h0d, 8'h09, 8'h0e};
        vecs[0] = '{0, 1'b0, 128'hdb135345_01010101_01010101_01010101,
                             128'h8e4da1bc_01010101_01010101_01010101, 0};
        vecs[1] = '{2, 1'b1, 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6,
                             128'hdb135345_f20a225c_01010101_d4d4d4d5, 0};
        vecs[2] = '{1, 1'b0, 128'hc6c6c6c6_2d26314c_f20a225c_d4d4d4d5,
                             128'hc6c6c6c6_4d7ebdf8_9fdc589d_d5d5d7d6, 5};
        vecs[3] = '{0, 1'b1, 128'hc6c6c6c6_4d7ebdf8_9fdc589d_d5d5d7d6,
                             128'hc6c6c6c6_2d26314c_f20a225c_d4d4d4d5, 0};
        vecs[4] = '{2, 1'b0, 128'hdb135345_f20a225c_01010101_d4d4d4d5,
                             128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 0};
        vecs[5] = '{1, 1'b1, 128'h8e4da1bc_01010101_01010101_01010101,
                             128'hdb135345_01010101_01010101_01010101, 0};
        for (int k = 0; k < 3; k++) in_state[k] = '0;

        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_flags", {125'd0, in_ready[k], out_valid[k], busy[k]}, 128'b100);
            chk("reset_state", out_state[k], 128'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_block(vecs[i].k, vecs[i].st, vecs[i].inv, 1'b0, vecs[i].exp, vecs[i].hold);

        // Round trip on every width: forward against the model, inverse back to the original.
        for (int k = 0; k < 3; k++) begin
            st = {$urandom, $urandom, $urandom, $urandom};
            fw = model(st, 1'b0);
            run_block(k, st, 1'b0, 1'b0, fw, 0);
            run_block(k, fw, 1'b1, 1'b0, st, 0);
        end

        // Reset in the second RUN cycle of the one-column build.
        in_state[0] = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
        in_inv[0] = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        chk("abort_flags", {125'd0, in_ready[0], out_valid[0], busy[0]}, 128'b100);
        chk("abort_state", out_state[0], 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_block(0, 128'hc6c6c6c6_2d26314c_f20a225c_d4d4d4d5, 1'b0, 1'b0,
                  128'hc6c6c6c6_4d7ebdf8_9fdc589d_d5d5d7d6, 0);

        for (int k = 0; k < 3; k++) b2b(k);

`ifdef MIXCOL_BYPASS_EN
        run_block(0, 128'hd4d4d4d5_2d26314c_f20a225c_c6c6c6c6, 1'b0, 1'b1,
                  128'hd4d4d4d5_2d26314c_f20a225c_c6c6c6c6, 0);
        run_block(2, 128'hd4d4d4d5_8e4da1bc_01010101_db135345, 1'b1, 1'b1,
                  128'hd4d4d4d5_8e4da1bc_01010101_db135345, 0);
`endif

        chk("scoreboard_empty", 128'(sb_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
